// File: rtl/console_io_core_if.sv
// Player I/O and video-timing bundle for the console front end.
// The master side drives raw buttons and switches; the slave side returns the debounced levels, the timing signals and the game state.
interface console_io_core_if;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic        setSpeed;
  logic        resetSw;
  logic        startGame;
  logic        pauseGame;
  logic        dead;

  logic        out_up;
  logic        out_down;
  logic        out_left;
  logic        out_right;
  logic        out_speed;
  logic        hsync;
  logic        vsync;
  logic        video_enable;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic [2:0]  stateGame;

  modport master (
    output up, down, left, right, setSpeed, resetSw, startGame, pauseGame, dead,
    input  out_up, out_down, out_left, out_right, out_speed,
    input  hsync, vsync, video_enable, pixel_x, pixel_y, stateGame
  );

  modport slave (
    input  up, down, left, right, setSpeed, resetSw, startGame, pauseGame, dead,
    output out_up, out_down, out_left, out_right, out_speed,
    output hsync, vsync, video_enable, pixel_x, pixel_y, stateGame
  );
endinterface

// File: rtl/console_io_core.sv
// Console front end: 800x600@72 SVGA timing, eight input debouncers and the top-level game FSM.
// Sync outputs line up with pixel_x/pixel_y; debounced levels lag a stable input by COUNTER_LIMITE+3 clocks; there is no backpressure.
module console_io_core #(
  parameter int                  INTERVAL       = 20,
  parameter logic [INTERVAL-1:0] COUNTER_LIMITE = 20'hfffff
) (
  input  logic              clk,
  input  logic              reset,
  console_io_core_if.slave  io
);

  localparam logic [10:0] H_LAST       = 11'd1039;
  localparam logic [10:0] H_ACTIVE     = 11'd800;
  localparam logic [10:0] H_SYNC_FIRST = 11'd856;
  localparam logic [10:0] H_SYNC_LAST  = 11'd975;
  localparam logic [9:0]  V_LAST       = 10'd665;
  localparam logic [9:0]  V_ACTIVE     = 10'd600;
  localparam logic [9:0]  V_SYNC_FIRST = 10'd637;
  localparam logic [9:0]  V_SYNC_LAST  = 10'd642;

  localparam logic [INTERVAL-1:0] CNT_ONE = 1;

  localparam int DB_UP     = 0;
  localparam int DB_DOWN   = 1;
  localparam int DB_LEFT   = 2;
  localparam int DB_RIGHT  = 3;
  localparam int DB_SPEED  = 4;
  localparam int DB_RESET  = 5;
  localparam int DB_START  = 6;
  localparam int DB_PAUSE  = 7;
  localparam int DB_N      = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_PAUSED    = 3'd2,
    ST_GAME_OVER = 3'd3
  } state_t;

  // ---------------------------------------------------------------- timing
  logic [10:0] r_hcnt;
  logic [9:0]  r_vcnt;
  logic        r_hsync;
  logic        r_vsync;
  logic        w_h_wrap;
  logic [10:0] w_hcnt_nxt;
  logic [9:0]  w_vcnt_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;

  assign w_h_wrap   = (r_hcnt == H_LAST);
  assign w_hcnt_nxt = w_h_wrap ? 11'd0 : (r_hcnt + 11'd1);
  assign w_vcnt_nxt = !w_h_wrap          ? r_vcnt :
                      (r_vcnt == V_LAST) ? 10'd0  : (r_vcnt + 10'd1);

  // Sync flops decode the upcoming count so they stay aligned with pixel_x/pixel_y.
  assign w_hsync_nxt = (w_hcnt_nxt >= H_SYNC_FIRST) && (w_hcnt_nxt <= H_SYNC_LAST);
  assign w_vsync_nxt = (w_vcnt_nxt >= V_SYNC_FIRST) && (w_vcnt_nxt <= V_SYNC_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hcnt  <= 11'd0;
      r_vcnt  <= 10'd0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
    end
  end

  // ------------------------------------------------------------ debouncers
  logic [DB_N-1:0]     w_raw;
  logic [DB_N-1:0]     r_sync1;
  logic [DB_N-1:0]     r_sync2;
  logic [DB_N-1:0]     r_db;
  logic [INTERVAL-1:0] r_cnt [DB_N];

  // setSpeed is an active-low pushbutton; everything else is active-high.
  assign w_raw = {io.pauseGame, io.startGame, io.resetSw, ~io.setSpeed,
                  io.right, io.left, io.down, io.up};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < DB_N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < DB_N; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == COUNTER_LIMITE) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // -------------------------------------------------------------- game FSM
  state_t r_state;
  state_t w_state_nxt;
  logic   w_db_reset;
  logic   w_db_start;
  logic   w_db_pause;

  assign w_db_reset = r_db[DB_RESET];
  assign w_db_start = r_db[DB_START];
  assign w_db_pause = r_db[DB_PAUSE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_db_reset) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_db_start) w_state_nxt = ST_PLAYING;
        end
        ST_PLAYING: begin
          // Death outranks a pause request arriving in the same cycle.
          if (io.dead)         w_state_nxt = ST_GAME_OVER;
          else if (w_db_pause) w_state_nxt = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (!w_db_pause) w_state_nxt = ST_PLAYING;
        end
        ST_GAME_OVER: begin
          if (!w_db_start) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- outputs
  assign io.out_up       = r_db[DB_UP];
  assign io.out_down     = r_db[DB_DOWN];
  assign io.out_left     = r_db[DB_LEFT];
  assign io.out_right    = r_db[DB_RIGHT];
  assign io.out_speed    = r_db[DB_SPEED];
  assign io.hsync        = r_hsync;
  assign io.vsync        = r_vsync;
  assign io.video_enable = (r_hcnt < H_ACTIVE) && (r_vcnt < V_ACTIVE);
  assign io.pixel_x      = r_hcnt;
  assign io.pixel_y      = r_vcnt;
  assign io.stateGame    = r_state;

endmodule

// File: tb/tb_console_io_core.sv
// Bench for console_io_core: a cycle-count/sample-window model checked every clock, plus directed literal checks.
module tb_console_io_core;
  localparam int LIM = 4;
  localparam int HT  = 1040;
  localparam int VT  = 666;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  console_io_core_if io();

  console_io_core #(
    .INTERVAL       (20),
    .COUNTER_LIMITE (20'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int errors = 0;
  int checks = 0;

  // ------------------------------------------------------------ model
  // t = rising edges since reset release; the counters are pure functions of it.
  // A debounced level flips once the raw samples taken 2..LIM+2 edges ago all disagree with it.
  int unsigned t;
  bit          hist [8][LIM+2];
  bit          m_db [8];
  int          m_state;

  function automatic bit raw_bit(int i);
    case (i)
      0: return io.up;
      1: return io.down;
      2: return io.left;
      3: return io.right;
      4: return ~io.setSpeed;
      5: return io.resetSw;
      6: return io.startGame;
      default: return io.pauseGame;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t       = 0;
      m_state = 0;
      for (int i = 0; i < 8; i++) begin
        m_db[i] = 1'b0;
        for (int j = 0; j < LIM + 2; j++) hist[i][j] = 1'b0;
      end
    end else begin
      t = t + 1;
      if (m_db[5]) m_state = 0;
      else begin
        case (m_state)
          0: if (m_db[6]) m_state = 1;
          1: if (io.dead) m_state = 3; else if (m_db[7]) m_state = 2;
          2: if (!m_db[7]) m_state = 1;
          3: if (!m_db[6]) m_state = 0;
          default: m_state = 0;
        endcase
      end
      for (int i = 0; i < 8; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 1; j <= LIM + 1; j++)
          if (hist[i][j] == m_db[i]) all_diff = 1'b0;
        if (all_diff) m_db[i] = ~m_db[i];
        for (int j = LIM + 1; j >= 1; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = raw_bit(i);
      end
    end
  end

  // ---------------------------------------------------- per-cycle compare
  always @(negedge clk) begin
    int h, v;
    logic [31:0] exp_v, act_v;
    h = int'(t % HT);
    v = int'((t / HT) % VT);
    exp_v = {m_db[0], m_db[1], m_db[2], m_db[3], m_db[4],
             1'(h >= 856 && h <= 975), 1'(v >= 637 && v <= 642),
             1'(h < 800 && v < 600), 11'(h), 10'(v), 3'(m_state)};
    act_v = {io.out_up, io.out_down, io.out_left, io.out_right, io.out_speed,
             io.hsync, io.vsync, io.video_enable, io.pixel_x, io.pixel_y, io.stateGame};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cmp t=%0d actual=%h required=%h", t, act_v, exp_v);
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_px(input int target, input int budget);
    int k;
    k = 0;
    while (int'(io.pixel_x) != target && k < budget) begin
      edges(1);
      k++;
    end
    check("wait_pixel_x", int'(io.pixel_x), target);
  endtask

  task automatic settle();
    edges(10);
  endtask

  // ----------------------------------------------------------- stimulus
  initial begin
    io.up = 0; io.down = 0; io.left = 0; io.right = 0; io.setSpeed = 1;
    io.resetSw = 0; io.startGame = 0; io.pauseGame = 0; io.dead = 0;

    edges(2);
    check("rst_pixel_x", int'(io.pixel_x), 0);
    check("rst_pixel_y", int'(io.pixel_y), 0);
    check("rst_state", int'(io.stateGame), 0);
    check("rst_video_en", int'(io.video_enable), 1);
    check("rst_hsync", int'(io.hsync), 0);
    reset = 1'b1;
    edges(3);
    check("px_after_3", int'(io.pixel_x), 3);

    // Debounce latency and glitch rejection.
    io.up = 1;
    edges(6); check("up_at_6", int'(io.out_up), 0);
    edges(1); check("up_at_7", int'(io.out_up), 1);
    io.left = 1; edges(3); io.left = 0;
    edges(12); check("left_glitch", int'(io.out_left), 0);
    io.setSpeed = 0;
    edges(6); check("speed_at_6", int'(io.out_speed), 0);
    edges(1); check("speed_at_7", int'(io.out_speed), 1);

    // Horizontal timing boundaries.
    wait_px(855, 2 * HT);
    check("hs_855", int'(io.hsync), 0);
    edges(1);   check("hs_856", int'(io.hsync), 1);
    edges(119); check("hs_975", int'(io.hsync), 1);
    check("px_975", int'(io.pixel_x), 975);
    edges(1);   check("hs_976", int'(io.hsync), 0);
    wait_px(799, 2 * HT);
    check("ve_799", int'(io.video_enable), 1);
    edges(1);   check("ve_800", int'(io.video_enable), 0);
    wait_px(1039, 2 * HT);
    edges(1);   check("px_wrap", int'(io.pixel_x), 0);

    // FSM happy path.
    io.startGame = 1;
    edges(7); check("start_at_7", int'(io.stateGame), 0);
    edges(1); check("start_at_8", int'(io.stateGame), 1);
    io.pauseGame = 1; settle(); check("paused", int'(io.stateGame), 2);
    io.pauseGame = 0; settle(); check("resumed", int'(io.stateGame), 1);
    io.dead = 1; edges(1); check("dead_1clk", int'(io.stateGame), 3);
    io.dead = 0; edges(2); check("over_hold", int'(io.stateGame), 3);
    io.startGame = 0; settle(); check("rearm_idle", int'(io.stateGame), 0);

    // Dead and debounced pause seen in the same cycle.
    io.startGame = 1; settle(); check("play_again", int'(io.stateGame), 1);
    io.pauseGame = 1; edges(7);
    io.dead = 1; edges(1); check("dead_over_pause", int'(io.stateGame), 3);
    io.dead = 0; io.pauseGame = 0; io.startGame = 0;
    settle(); check("idle_again", int'(io.stateGame), 0);

    // resetSw from PAUSED, held while start stays high.
    io.startGame = 1; settle(); check("play_3", int'(io.stateGame), 1);
    io.pauseGame = 1; settle(); check("paused_2", int'(io.stateGame), 2);
    io.resetSw = 1; settle(); check("rsw_idle", int'(io.stateGame), 0);
    io.pauseGame = 0; edges(20); check("rsw_hold", int'(io.stateGame), 0);
    io.resetSw = 0;
    edges(7); check("rsw_rel_7", int'(io.stateGame), 0);
    edges(1); check("rsw_rel_8", int'(io.stateGame), 1);

    // Asynchronous reset mid-line.
    wait_px(500, 2 * HT);
    check("pre_rst_state", int'(io.stateGame), 1);
    reset = 1'b0;
    #1;
    check("arst_pixel_x", int'(io.pixel_x), 0);
    check("arst_pixel_y", int'(io.pixel_y), 0);
    check("arst_state", int'(io.stateGame), 0);
    check("arst_outs", int'({io.out_up, io.out_down, io.out_left, io.out_right, io.out_speed}), 0);
    edges(2);
    reset = 1'b1;

    // Free run across many lines; the model compare covers the vertical count.
    edges(50000);
    check("final_pixel_y", int'(io.pixel_y), int'((t / HT) % VT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
